// File: rtl/eth_frame_packer.sv
// rtl/eth_frame_packer.sv - captures ADC word bursts and emits one Ethernet frame per burst
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   eth_en     burst-read strobe; din is valid one cycle later
//   din        16-bit FIFO read data
//   tx_tdata   frame byte to the MAC
//   tx_tvalid  tx_tdata valid
//   tx_tready  MAC accepts the byte when tvalid && tready
//   tx_tlast   final byte of the frame
//   busy       high whenever the packer is not IDLE
//   overrun    sticky: an input word was dropped
//   seq_num    sequence number of the next frame
module eth_frame_packer #(
  parameter int          MAX_WORDS = 512,
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        eth_en,
  input  logic [15:0] din,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        tx_tlast,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] seq_num
);

  localparam int AW = $clog2(MAX_WORDS);
  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, HEADER, PAYLOAD} state_t;

  state_t         state, state_next;
  logic           eth_en_d;
  logic [CW-1:0]  count;
  logic [AW-1:0]  rd_addr;
  logic [15:0]    rd_data;
  logic [7:0]     lo_hold;
  logic [15:0]    nxt_idx;
  logic [15:0]    payload_end;
  logic [15:0]    frame_len;
  logic [143:0]   hdr;
  logic [4:0]     hdr_sel;
  logic [7:0]     nxt_byte;
  logic           is_hi_byte;
  logic           load;
  logic           accept_last;
  logic           wr_en;
  logic           space_left;

  logic [15:0] mem [MAX_WORDS];

  assign space_left  = count < CW'(MAX_WORDS);
  assign wr_en       = eth_en_d && (state == CAPTURE) && space_left;
  assign payload_end = 16'd18 + {15'(count), 1'b0};
  assign frame_len   = (payload_end < 16'd60) ? 16'd60 : payload_end;
  assign hdr         = {DST_MAC, SRC_MAC, ETHERTYPE, seq_num, 16'(count)};
  assign hdr_sel     = 5'd17 - nxt_idx[4:0];
  assign is_hi_byte  = (nxt_idx >= 16'd18) && (nxt_idx < payload_end) && !nxt_idx[0];
  assign accept_last = tx_tvalid && tx_tready && tx_tlast;
  // A new byte is loaded whenever the output register is empty or being drained,
  // so the stream runs at one byte per cycle with no bubbles.
  assign load = ((state == HEADER) || (state == PAYLOAD)) && (!tx_tvalid || tx_tready)
                && (nxt_idx < frame_len);
  assign busy = (state != IDLE);

  always_comb begin
    nxt_byte = 8'h00;
    if (nxt_idx < 16'd18)
      nxt_byte = hdr[{hdr_sel, 3'b000} +: 8];
    else if (nxt_idx < payload_end)
      nxt_byte = nxt_idx[0] ? lo_hold : rd_data[15:8];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (eth_en) state_next = CAPTURE;
      CAPTURE: if (!eth_en_d) state_next = (count != '0) ? HEADER : IDLE;
      HEADER:  if (load && (nxt_idx == 16'd17)) state_next = PAYLOAD;
      PAYLOAD: if (accept_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Buffer RAM: synchronous write, registered read. rd_addr is advanced as the
  // high byte of a word is loaded, so the next word is fetched while the low
  // byte (parked in lo_hold) goes out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[AW-1:0]] <= din;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eth_en_d  <= 1'b0;
      count     <= '0;
      overrun   <= 1'b0;
      seq_num   <= 16'h0000;
      tx_tdata  <= 8'h00;
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      nxt_idx   <= 16'h0000;
      rd_addr   <= '0;
      lo_hold   <= 8'h00;
    end else begin
      eth_en_d <= eth_en;
      if (wr_en) count <= count + CW'(1);
      if (eth_en_d && !wr_en) overrun <= 1'b1;

      if (load) begin
        tx_tdata  <= nxt_byte;
        tx_tvalid <= 1'b1;
        tx_tlast  <= (nxt_idx == frame_len - 16'd1);
        nxt_idx   <= nxt_idx + 16'd1;
        if (is_hi_byte) begin
          lo_hold <= rd_data[7:0];
          rd_addr <= rd_addr + AW'(1);
        end
      end else if (accept_last) begin
        tx_tvalid <= 1'b0;
        tx_tlast  <= 1'b0;
        nxt_idx   <= 16'h0000;
        rd_addr   <= '0;
        count     <= '0;
        seq_num   <= seq_num + 16'd1;
      end else if (tx_tvalid && tx_tready) begin
        tx_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_packer.sv
// tb/tb_eth_frame_packer.sv - self-checking bench for eth_frame_packer
module tb_eth_frame_packer;

  logic        clk;
  logic        rstn;
  logic        eth_en;
  logic [15:0] din;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic        tx_tlast;
  logic        busy;
  logic        overrun;
  logic [15:0] seq_num;

  eth_frame_packer dut (
    .clk(clk), .rstn(rstn), .eth_en(eth_en), .din(din),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .tx_tlast(tx_tlast), .busy(busy), .overrun(overrun), .seq_num(seq_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  bit rdy_mode = 1'b0;
  always @(posedge clk) begin
    #2;
    tx_tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [7:0] rx[$];
  logic [7:0] last_frame[$];
  int         frames_done = 0;
  int         proto_err   = 0;
  bit         stall_prev  = 1'b0;
  bit         in_frame    = 1'b0;
  logic [7:0] pd;
  logic       pl;

  always @(negedge clk) begin
    if (!rstn) begin
      rx.delete();
      stall_prev = 1'b0;
      in_frame   = 1'b0;
    end else begin
      if (stall_prev && (!tx_tvalid || tx_tdata !== pd || tx_tlast !== pl)) proto_err++;
      if (in_frame && !tx_tvalid) proto_err++;
      if (tx_tvalid && tx_tready) begin
        rx.push_back(tx_tdata);
        in_frame = !tx_tlast;
        if (tx_tlast) begin
          last_frame = rx;
          rx.delete();
          frames_done++;
        end
      end
      stall_prev = tx_tvalid && !tx_tready;
      pd = tx_tdata;
      pl = tx_tlast;
    end
  end

  task automatic send_burst(input int n, input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i <= n; i++) begin
      @(posedge clk);
      #2;
      eth_en = (i < n);
      din    = (i >= 1) ? base + 16'(i - 1) * step : 16'h0000;
    end
  endtask

  task automatic wait_frame(input string name, input int start_cnt);
    for (int c = 0; c < 6000 && frames_done == start_cnt; c++) @(negedge clk);
    check({name, "_done"}, 32'(frames_done != start_cnt), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_frame(input string name, input logic [15:0] seq, input int n,
                             input logic [15:0] base, input logic [15:0] step);
    logic [7:0]   e[$];
    logic [143:0] hdr;
    logic [15:0]  w;
    int           nw;
    int           bad;
    nw  = (n > 512) ? 512 : n;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h88B5, seq, 16'(nw)};
    for (int k = 0; k < 18; k++) e.push_back(hdr[143 - 8 * k -: 8]);
    for (int i = 0; i < nw; i++) begin
      w = base + 16'(i) * step;
      e.push_back(w[15:8]);
      e.push_back(w[7:0]);
    end
    while (e.size() < 60) e.push_back(8'h00);
    check({name, "_len"}, 32'(last_frame.size()), 32'(e.size()));
    bad = -1;
    for (int i = 0; i < e.size() && i < last_frame.size(); i++)
      if (bad < 0 && last_frame[i] !== e[i]) bad = i;
    check({name, "_first_bad_byte"}, 32'(bad), 32'hFFFF_FFFF);
  endtask

  typedef struct {
    int          n;
    logic [15:0] base;
    logic [15:0] step;
    bit          rdy;
    int          exp_len;
    logic [15:0] exp_cnt;
    bit          exp_ovr;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] exp_seq;
  logic [15:0] cnt_act;
  int          start;

  initial begin
    vecs[0] = '{512, 16'h0000, 16'h0001, 1'b0, 1042, 16'h0200, 1'b0};
    vecs[1] = '{5,   16'hA5A5, 16'h0000, 1'b0, 60,   16'h0005, 1'b0};
    vecs[2] = '{512, 16'h0000, 16'h0001, 1'b1, 1042, 16'h0200, 1'b0};
    vecs[3] = '{1,   16'h1234, 16'h0000, 1'b1, 60,   16'h0001, 1'b0};
    vecs[4] = '{21,  16'h1234, 16'h1111, 1'b1, 60,   16'h0015, 1'b0};
    vecs[5] = '{24,  16'hFF00, 16'h0101, 1'b0, 66,   16'h0018, 1'b0};
    vecs[6] = '{520, 16'h0000, 16'h0001, 1'b0, 1042, 16'h0200, 1'b1};

    rstn = 1'b0; eth_en = 1'b0; din = 16'h0000; tx_tready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tvalid", 32'(tx_tvalid), 32'd0);
    check("rst_tlast", 32'(tx_tlast), 32'd0);
    check("rst_tdata", 32'(tx_tdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_seq", 32'(seq_num), 32'd0);
    @(posedge clk); #2 rstn = 1'b1;

    exp_seq = 16'h0000;
    for (int v = 0; v < 7; v++) begin
      rdy_mode = vecs[v].rdy;
      start = frames_done;
      send_burst(vecs[v].n, vecs[v].base, vecs[v].step);
      wait_frame($sformatf("vec%0d", v), start);
      check_frame($sformatf("vec%0d", v), exp_seq, vecs[v].n, vecs[v].base, vecs[v].step);
      check($sformatf("vec%0d_len_tbl", v), 32'(last_frame.size()), 32'(vecs[v].exp_len));
      cnt_act = (last_frame.size() >= 18) ? {last_frame[16], last_frame[17]} : 16'hDEAD;
      check($sformatf("vec%0d_cnt_field", v), 32'(cnt_act), 32'(vecs[v].exp_cnt));
      exp_seq = exp_seq + 16'd1;
      check($sformatf("vec%0d_seq", v), 32'(seq_num), 32'(exp_seq));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
      check($sformatf("vec%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ovr));
      check($sformatf("vec%0d_protocol", v), 32'(proto_err), 32'd0);
    end

    // Second eth_en pulse while the payload is streaming.
    rdy_mode = 1'b0;
    start = frames_done;
    send_burst(30, 16'h3000, 16'h0003);
    for (int c = 0; c < 2000 && rx.size() < 22; c++) @(negedge clk);
    @(posedge clk); #2 eth_en = 1'b1; din = 16'hDEAD;
    repeat (3) @(posedge clk);
    #2 eth_en = 1'b0;
    wait_frame("overlap", start);
    check_frame("overlap", exp_seq, 30, 16'h3000, 16'h0003);
    exp_seq = exp_seq + 16'd1;
    check("overlap_overrun", 32'(overrun), 32'd1);
    repeat (150) @(negedge clk);
    check("overlap_no_extra", 32'(frames_done), 32'(start + 1));
    check("overlap_busy", 32'(busy), 32'd0);

    // Sequence number wrap.
    @(negedge clk);
    force dut.seq_num = 16'hFFFF;
    #1 release dut.seq_num;
    #1 check("wrap_forced", 32'(seq_num), 32'h0000_FFFF);
    start = frames_done;
    send_burst(1, 16'hBEEF, 16'h0000);
    wait_frame("wrap", start);
    check_frame("wrap", 16'hFFFF, 1, 16'hBEEF, 16'h0000);
    check("wrap_seq", 32'(seq_num), 32'd0);

    // Asynchronous reset in the middle of a frame.
    start = frames_done;
    send_burst(512, 16'h0000, 16'h0001);
    for (int c = 0; c < 3000 && rx.size() < 300; c++) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("arst_tvalid", 32'(tx_tvalid), 32'd0);
    check("arst_tlast", 32'(tx_tlast), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_seq", 32'(seq_num), 32'd0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    check("arst_no_frame", 32'(frames_done), 32'(start));
    check("arst_overrun", 32'(overrun), 32'd0);
    start = frames_done;
    send_burst(5, 16'h0F0E, 16'h0001);
    wait_frame("post_rst", start);
    check_frame("post_rst", 16'h0000, 5, 16'h0F0E, 16'h0001);
    check("post_rst_seq", 32'(seq_num), 32'd1);
    check("post_rst_protocol", 32'(proto_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
